// File: rtl/decoder_scan_nbit.sv
// Registered N-to-2^N one-hot decoder: direct mode decodes `a`, scan mode
// steps through every output holding each for dwell+1 enabled cycles.
module decoder_scan_nbit #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       a,
  input  logic               enable,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2**N-1:0]    y,
  output logic [N-1:0]       idx,
  output logic               wrap
);

  localparam int OUT_W = 2**N;

  logic [OUT_W-1:0]   y_q, y_d;
  logic [N-1:0]       idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // Next index is decided first so y always decodes the same index that idx
  // registers on this edge; the >= compare keeps cnt bounded by dwell.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    y_d    = '0;
    if (!mode) begin
      idx_d = a;
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q >= dwell) begin
        cnt_d  = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == {N{1'b1}});
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    y_d[idx_d] = enable;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q    <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      y_q    <= y_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
